cpu_mult_pipe: RTL
==================

# cpu_mult_pipe

Parametrised pipelined integer multiplier for the CPU M-stage, succeeding the fixed three-partial-product 16×16 multiply cell. Computes the full 2×DATA_W product from four registered half-width partial products and returns either the low word (MUL) or the high word under signed×signed, signed×unsigned or unsigned×unsigned interpretation (MULXSS/MULXSU/MULXUU). Latency is configurable. A valid tag travels with each operation, the pipeline honours the existing M_en stall, and a flush kills in-flight operations.

## Interface
- DATA_W, 32, operand and result width; even, 8..64; HALF_W = DATA_W/2.
- PIPE_STAGES, 2, register stages from issue to result; legal values 2..4.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- E_src1  in  DATA_W  multiplicand A.
- E_src2  in  DATA_W  multiplier B.
- E_op  in  2  operation: 0 MUL (low word), 1 MULXUU, 2 MULXSU (A signed, B unsigned), 3 MULXSS.
- E_valid  in  1  issue strobe; sampled only when M_en=1.
- M_en  in  1  pipeline advance enable; 0 freezes every stage.
- M_flush  in  1  kill all in-flight and same-cycle issued operations.
- M_valid  out  1  M_result holds a completed operation.
- M_result  out  DATA_W  selected product word.
- M_busy  out  1  OR of all stage valid bits, including the output stage.

## Operation
- Stage 1 registers: pp_ll = A[lo]×B[lo], pp_lh = A[lo]×B[hi], pp_hl = A[hi]×B[lo], pp_hh = A[hi]×B[hi]. All are HALF_W×HALF_W unsigned products of width DATA_W. Stage 1 also registers E_op, sign(A)=A[MSB] and sign(B)=B[MSB] gated by op, the raw A and B for correction, and the valid bit.
- Stage 2 forms the unsigned 2×DATA_W sum P = pp_ll + (pp_lh + pp_hl)<<HALF_W + pp_hh<<DATA_W. The middle sum is DATA_W+1 bits and the carry must be kept.
- Signed correction applies to the high word only, modulo 2^DATA_W:
  - hi = P_hi − (A signed && A<0 ? B : 0) − (B signed && B<0 ? A : 0).
  - MULXSU treats B as unsigned; MULXUU applies no correction.
- Result select: MUL → P_lo; all other ops → corrected hi.
- Stages 3..PIPE_STAGES are pure delay registers for valid, result and op.
- Advance: when M_en=1 every stage loads from its predecessor, and stage 1 loads valid = E_valid & ~M_flush. When M_en=0 all data and valid registers hold.
- Flush: M_flush=1 clears every valid bit on that edge regardless of M_en, and drops any operation issued in the same cycle. Data registers may keep stale values.
- Throughput: one operation per cycle with M_en=1. There is no backpressure output; the CPU controls flow with M_en.

## Timing
- Reset (async assert, sync release): all valid bits 0, all data registers 0; M_valid=0, M_result=0, M_busy=0.
- Latency: an operation issued at edge t with M_en=1 on each following edge appears with M_valid=1 after edge t+PIPE_STAGES−1, i.e. exactly PIPE_STAGES M_en-qualified edges.
- Stalls: each M_en=0 cycle adds one cycle of latency. M_valid and M_result stay stable while stalled.
- M_valid is high only while the output stage holds the result. With M_en=1 it is a one-cycle pulse per operation.
- Reset asserted mid-operation: all in-flight work is lost immediately, with no output glitch beyond the clear.
- Flush and stall in the same cycle: the flush wins and valids clear.
- Flush and issue in the same cycle: the issued operation is discarded.

## Structure
- Package cpu_mult_pkg holds:
  - the op enum (MUL_LO, MULXUU, MULXSU, MULXSS);
  - the HALF_W derivation function;
  - a PIPE_STAGES range-check constant.
- Sub-module cpu_mult_pp: one registered HALF_W×HALF_W unsigned multiplier with enable and async clear. It is instantiated four times so synthesis maps it to DSP blocks.
- The top level holds the stage-2 adder, sign correction, delay chain and valid/flush control.

## Test plan
- Default parameters, M_en=1. Issue A=B=0xFFFFFFFF under each op. Required results: MUL → 0x00000001, MULXUU → 0xFFFFFFFE, MULXSS → 0x00000000, MULXSU → 0xFFFFFFFF, each exactly 2 cycles after issue.
- MULXSS with A=B=0x80000000 → 0x40000000. MUL with A=0x00012345, B=0x00010000 → 0x23450000.
- Back-to-back issue of 8 random ops with M_en=1 → 8 consecutive M_valid pulses, all matching a 64-bit reference model.
- Issue one op, then hold M_en=0 for 3 cycles → M_valid appears 5 cycles after issue with the correct value, and M_result stays stable while M_valid is high and stalled.
- Issue 2 ops back-to-back, then assert M_flush together with a third issue → M_valid never rises and M_busy drops to 0 on the next edge.
- PIPE_STAGES=4, DATA_W=16: assert reset_n=0 mid-flight → all outputs 0 asynchronously. After release, a MULXUU of 0xFFFF×0xFFFF returns 0xFFFE after 4 cycles.

Source files
------------

// File: rtl/cpu_mult_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined M-stage multiplier.
package cpu_mult_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MULXUU = 2'd1,
    MULXSU = 2'd2,
    MULXSS = 2'd3
  } mult_op_e;

  localparam int PIPE_STAGES_MIN = 2;
  localparam int PIPE_STAGES_MAX = 4;

  function automatic int half_w(input int data_w);
    return data_w / 2;
  endfunction

  // Out-of-range stage counts are pulled back into the legal window.
  function automatic int clamp_stages(input int ps);
    if (ps < PIPE_STAGES_MIN) return PIPE_STAGES_MIN;
    if (ps > PIPE_STAGES_MAX) return PIPE_STAGES_MAX;
    return ps;
  endfunction

endpackage

// File: rtl/cpu_mult_pipe_if.sv
// E-stage issue / M-stage result bundle for the multiplier.
// E_valid is taken only on edges where M_en=1; M_flush kills everything in
// flight plus a same-cycle issue; M_valid marks a completed result while held.
interface cpu_mult_pipe_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] E_src1;
  logic [DATA_W-1:0] E_src2;
  logic [1:0]        E_op;
  logic              E_valid;
  logic              M_en;
  logic              M_flush;
  logic              M_valid;
  logic [DATA_W-1:0] M_result;
  logic              M_busy;

  modport master (
    output E_src1, E_src2, E_op, E_valid, M_en, M_flush,
    input  M_valid, M_result, M_busy
  );

  modport slave (
    input  E_src1, E_src2, E_op, E_valid, M_en, M_flush,
    output M_valid, M_result, M_busy
  );
endinterface

// File: rtl/cpu_mult_pipe_pp.sv
// One registered HALF_W x HALF_W unsigned partial product (DSP-friendly).
module cpu_mult_pp #(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_en,
  input  logic [HALF_W-1:0]   i_a,
  input  logic [HALF_W-1:0]   i_b,
  output logic [2*HALF_W-1:0] o_p
);
  logic [2*HALF_W-1:0] w_a;
  logic [2*HALF_W-1:0] w_b;
  logic [2*HALF_W-1:0] r_p;

  assign w_a = {{HALF_W{1'b0}}, i_a};
  assign w_b = {{HALF_W{1'b0}}, i_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_p <= '0;
    else if (i_en) r_p <= w_a * w_b;
  end

  assign o_p = r_p;
endmodule

// File: rtl/cpu_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier: four registered partial products,
// stage-2 sum with signed high-word correction, then a pure delay chain.
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  cpu_mult_pipe_if.slave bus
);
  localparam int HALF_W   = half_w(DATA_W);
  localparam int N_STAGES = clamp_stages(PIPE_STAGES);

  logic [HALF_W-1:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;
  logic [DATA_W-1:0] w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh;
  mult_op_e          w_op;

  assign w_a_lo = bus.E_src1[HALF_W-1:0];
  assign w_a_hi = bus.E_src1[DATA_W-1:HALF_W];
  assign w_b_lo = bus.E_src2[HALF_W-1:0];
  assign w_b_hi = bus.E_src2[DATA_W-1:HALF_W];
  assign w_op   = mult_op_e'(bus.E_op);

  cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_ll (.clk(clk), .reset_n(reset_n), .i_en(bus.M_en),
                                          .i_a(w_a_lo), .i_b(w_b_lo), .o_p(w_pp_ll));
  cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_lh (.clk(clk), .reset_n(reset_n), .i_en(bus.M_en),
                                          .i_a(w_a_lo), .i_b(w_b_hi), .o_p(w_pp_lh));
  cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_hl (.clk(clk), .reset_n(reset_n), .i_en(bus.M_en),
                                          .i_a(w_a_hi), .i_b(w_b_lo), .o_p(w_pp_hl));
  cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_hh (.clk(clk), .reset_n(reset_n), .i_en(bus.M_en),
                                          .i_a(w_a_hi), .i_b(w_b_hi), .o_p(w_pp_hh));

  mult_op_e          r_s1_op;
  logic              r_s1_sa, r_s1_sb, r_s1_vld;
  logic [DATA_W-1:0] r_s1_a, r_s1_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_op  <= MUL_LO;
      r_s1_sa  <= 1'b0;
      r_s1_sb  <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      if (bus.M_flush)   r_s1_vld <= 1'b0;
      else if (bus.M_en) r_s1_vld <= bus.E_valid;
      if (bus.M_en) begin
        r_s1_op <= w_op;
        // Sign flags already folded with op so stage 2 only asks "subtract?".
        r_s1_sa <= bus.E_src1[DATA_W-1] && (w_op == MULXSU || w_op == MULXSS);
        r_s1_sb <= bus.E_src2[DATA_W-1] && (w_op == MULXSS);
        r_s1_a  <= bus.E_src1;
        r_s1_b  <= bus.E_src2;
      end
    end
  end

  logic [DATA_W:0]     w_mid;
  logic [2*DATA_W-1:0] w_p;
  logic [DATA_W-1:0]   w_hi, w_result;

  always_comb begin
    w_mid    = {1'b0, w_pp_lh} + {1'b0, w_pp_hl};
    w_p      = {{DATA_W{1'b0}}, w_pp_ll}
             + ({{(DATA_W-1){1'b0}}, w_mid} << HALF_W)
             + {w_pp_hh, {DATA_W{1'b0}}};
    w_hi     = w_p[2*DATA_W-1:DATA_W]
             - (r_s1_sa ? r_s1_b : '0)
             - (r_s1_sb ? r_s1_a : '0);
    w_result = (r_s1_op == MUL_LO) ? w_p[DATA_W-1:0] : w_hi;
  end

  logic [N_STAGES:2] r_vld;
  logic [DATA_W-1:0] r_res [2:N_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int k = 2; k <= N_STAGES; k++) r_res[k] <= '0;
    end else begin
      if (bus.M_flush) begin
        r_vld <= '0;
      end else if (bus.M_en) begin
        r_vld[2] <= r_s1_vld;
        for (int k = 3; k <= N_STAGES; k++) r_vld[k] <= r_vld[k-1];
      end
      if (bus.M_en) begin
        r_res[2] <= w_result;
        for (int k = 3; k <= N_STAGES; k++) r_res[k] <= r_res[k-1];
      end
    end
  end

  assign bus.M_valid  = r_vld[N_STAGES];
  assign bus.M_result = r_res[N_STAGES];
  assign bus.M_busy   = r_s1_vld | (|r_vld);
endmodule
